// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package sersub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..WIDTH-1; a one-bit counter still needs one bit.
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, bout set when the step borrows.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - borrow_in over WIDTH clocks.
// Start/busy/done handshake; a start seen in DONE is accepted back-to-back.
// Optional macro SERSUB_OVERFLOW_EN adds the signed-overflow output.
module serial_subtractor
   import sersub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERSUB_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   res_sr_q, res_sr_d;
   logic               bflop_q, bflop_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
`ifdef SERSUB_OVERFLOW_EN
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               ovf_q, ovf_d;
`endif

   logic               cell_d;
   logic               cell_bout;
   logic [WIDTH-1:0]   res_shifted;

   full_subtractor_cell u_cell (
      .x    (a_sr_q[0]),
      .y    (b_sr_q[0]),
      .bin  (bflop_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // New difference bit enters at the MSB so the word is aligned after WIDTH steps.
   assign res_shifted = (res_sr_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

   // Next-state, datapath load/shift and result capture on entry to DONE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      bflop_d  = bflop_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               a_sr_d  = a_in;
               b_sr_d  = b_in;
               bflop_d = borrow_in;
`ifdef SERSUB_OVERFLOW_EN
               a_msb_d = a_in[WIDTH-1];
               b_msb_d = b_in[WIDTH-1];
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_shifted;
            bflop_d  = cell_bout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d  = DONE;
               diff_d   = res_shifted;
               borrow_d = cell_bout;
`ifdef SERSUB_OVERFLOW_EN
               // cell_d is the MSB of the result on the final step.
               ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         bflop_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         bflop_q  <= bflop_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SERSUB_OVERFLOW_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
   assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 main instance plus a
// WIDTH=1 instance). Overflow checks are active when SERSUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         borrow_in = 1'b0;
   logic         busy, done, borrow;
   logic [W-1:0] diff;

   logic         s1_start = 1'b0;
   logic [0:0]   s1_a = '0;
   logic [0:0]   s1_b = '0;
   logic         s1_bin = 1'b0;
   logic         s1_busy, s1_done, s1_borrow;
   logic [0:0]   s1_diff;
`ifdef SERSUB_OVERFLOW_EN
   logic         overflow, s1_overflow;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   serial_subtractor #(.WIDTH(W)) u_dut (
      .clock(clock), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERSUB_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clock(clock), .reset(reset), .start(s1_start), .a_in(s1_a), .b_in(s1_b),
      .borrow_in(s1_bin), .busy(s1_busy), .done(s1_done), .diff(s1_diff), .borrow(s1_borrow)
`ifdef SERSUB_OVERFLOW_EN
      , .overflow(s1_overflow)
`endif
   );

   // Reference model: plain integer arithmetic on the operand values.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bin);
      int r;
      r = int'(a) - int'(b) - int'(bin);
      return W'(r);
   endfunction

   function automatic logic ref_borrow(input logic [W-1:0] a, b, input logic bin);
      return int'(a) < (int'(b) + int'(bin));
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic bin);
      byte sa, sb;
      int  r;
      sa = a;
      sb = b;
      r  = int'(sa) - int'(sb) - int'(bin);
      return (r < -128) || (r > 127);
   endfunction

   task automatic start_op(input logic [W-1:0] a, b, input logic bin);
      @(negedge clock);
      start = 1'b1; a_in = a; b_in = b; borrow_in = bin;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Number of clock edges after the accepting edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
      total++; if (diff !== 8'h00) begin bad++; $display("FAIL rst_diff got=%h want=00", diff); end
      total++; if (borrow !== 1'b0) begin bad++; $display("FAIL rst_borrow got=%b want=0", borrow); end
`ifdef SERSUB_OVERFLOW_EN
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow); end
`endif
      reset = 1'b1;
      @(negedge clock);
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_release busy=%b done=%b want 0 0", busy, done); end
      total++; if (s1_busy !== 1'b0 || s1_diff !== 1'b0) begin bad++; $display("FAIL rst_w1 busy=%b diff=%b want 0 0", s1_busy, s1_diff); end
      $display("reset sequence complete");
   endtask

   task automatic test_basic;
      start_op(8'h05, 8'h03, 1'b0);
      for (int i = 0; i <= 8; i++) begin
         @(negedge clock);
         if (i < 8) begin
            total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_run%0d busy=%b done=%b want 1 0", i, busy, done); end
         end else begin
            total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done done=%b busy=%b want 1 0", done, busy); end
            total++; if (diff !== 8'h02) begin bad++; $display("FAIL basic_diff got=%h want=02", diff); end
            total++; if (borrow !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b want=0", borrow); end
         end
      end
      @(negedge clock);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", done); end
      total++; if (diff !== 8'h02) begin bad++; $display("FAIL basic_hold got=%h want=02", diff); end
      $display("op 05-03-0 diff=%h borrow=%b", diff, borrow);
   endtask

   task automatic test_borrow;
      logic [W-1:0] ta [2] = '{8'h03, 8'h00};
      logic [W-1:0] tb [2] = '{8'h05, 8'h00};
      logic         tc [2] = '{1'b0, 1'b1};
      logic [W-1:0] td [2] = '{8'hFE, 8'hFF};
      int lat;
      for (int k = 0; k < 2; k++) begin
         start_op(ta[k], tb[k], tc[k]);
         wait_done(lat);
         total++; if (lat !== W) begin bad++; $display("FAIL borrow_lat%0d got=%0d want=%0d", k, lat, W); end
         total++; if (diff !== td[k]) begin bad++; $display("FAIL borrow_diff%0d got=%h want=%h", k, diff, td[k]); end
         total++; if (borrow !== 1'b1) begin bad++; $display("FAIL borrow_out%0d got=%b want=1", k, borrow); end
         $display("op %h-%h-%b diff=%h borrow=%b", ta[k], tb[k], tc[k], diff, borrow);
      end
   endtask

   task automatic test_back_to_back;
      logic exp_done, exp_busy;
      @(negedge clock);
      start = 1'b1; a_in = 8'hFF; b_in = 8'h0F; borrow_in = 1'b0;
      @(posedge clock);
      #1 a_in = 8'h10; b_in = 8'h01;
      for (int i = 0; i <= 18; i++) begin
         @(negedge clock);
         exp_done = (i == 8) || (i == 17);
         exp_busy = (i < 8) || (i >= 9 && i < 17);
         total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done%0d got=%b want=%b", i, done, exp_done); end
         total++; if (busy !== exp_busy) begin bad++; $display("FAIL b2b_busy%0d got=%b want=%b", i, busy, exp_busy); end
         if (i == 8) begin
            total++; if (diff !== 8'hF0) begin bad++; $display("FAIL b2b_diff1 got=%h want=F0", diff); end
            $display("op FF-0F-0 diff=%h borrow=%b", diff, borrow);
         end
         if (i == 9) start = 1'b0;
         if (i == 17) begin
            total++; if (diff !== 8'h0F) begin bad++; $display("FAIL b2b_diff2 got=%h want=0F", diff); end
            $display("op 10-01-0 diff=%h borrow=%b", diff, borrow);
         end
      end
   endtask

   task automatic test_ignore_start;
      start_op(8'h5A, 8'h23, 1'b0);
      for (int i = 0; i <= 8; i++) begin
         @(negedge clock);
         if (i < 8) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_early%0d got=%b want=0", i, done); end
         end else begin
            total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b want=1", done); end
            total++; if (diff !== ref_diff(8'h5A, 8'h23, 1'b0)) begin bad++; $display("FAIL ign_diff got=%h want=%h", diff, ref_diff(8'h5A, 8'h23, 1'b0)); end
         end
         if (i == 3) begin start = 1'b1; a_in = 8'hFF; b_in = 8'h00; borrow_in = 1'b1; end
         if (i == 4) start = 1'b0;
      end
      @(negedge clock);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_restart got=%b want=0", busy); end
      $display("op 5A-23-0 with stray start diff=%h", diff);
   endtask

   task automatic test_reset_mid_run;
      int lat;
      start_op(8'h9C, 8'h31, 1'b1);
      repeat (5) @(negedge clock);
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
      total++; if (diff !== 8'h00 || borrow !== 1'b0) begin bad++; $display("FAIL mid_clear diff=%h borrow=%b want 00 0", diff, borrow); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_nodone%0d got=%b want=0", i, done); end
      end
      reset = 1'b1;
      start_op(8'h40, 8'h11, 1'b0);
      wait_done(lat);
      total++; if (lat !== W || diff !== 8'h2F) begin bad++; $display("FAIL mid_after lat=%0d diff=%h want %0d 2F", lat, diff, W); end
      $display("op 40-11-0 after reset diff=%h", diff);
   endtask

   task automatic test_random;
      logic [W-1:0] a, b;
      logic         c;
      int           lat;
      for (int k = 0; k < 24; k++) begin
         a = W'($urandom);
         b = W'($urandom);
         c = 1'($urandom_range(0, 1));
         start_op(a, b, c);
         wait_done(lat);
         total++; if (lat !== W) begin bad++; $display("FAIL rnd_lat%0d got=%0d want=%0d", k, lat, W); end
         total++; if (diff !== ref_diff(a, b, c)) begin bad++; $display("FAIL rnd_diff%0d got=%h want=%h", k, diff, ref_diff(a, b, c)); end
         total++; if (borrow !== ref_borrow(a, b, c)) begin bad++; $display("FAIL rnd_borrow%0d got=%b want=%b", k, borrow, ref_borrow(a, b, c)); end
`ifdef SERSUB_OVERFLOW_EN
         total++; if (overflow !== ref_ovf(a, b, c)) begin bad++; $display("FAIL rnd_ovf%0d got=%b want=%b", k, overflow, ref_ovf(a, b, c)); end
`endif
         $display("op %h-%h-%b diff=%h borrow=%b", a, b, c, diff, borrow);
      end
   endtask

`ifdef SERSUB_OVERFLOW_EN
   task automatic test_overflow;
      logic [W-1:0] ta [2] = '{8'h80, 8'h7F};
      logic         to [2] = '{1'b1, 1'b0};
      int lat;
      for (int k = 0; k < 2; k++) begin
         start_op(ta[k], 8'h01, 1'b0);
         wait_done(lat);
         total++; if (diff !== ref_diff(ta[k], 8'h01, 1'b0)) begin bad++; $display("FAIL ovf_diff%0d got=%h want=%h", k, diff, ref_diff(ta[k], 8'h01, 1'b0)); end
         total++; if (overflow !== to[k]) begin bad++; $display("FAIL ovf_flag%0d got=%b want=%b", k, overflow, to[k]); end
         $display("op %h-01-0 diff=%h overflow=%b", ta[k], diff, overflow);
      end
   endtask
`endif

   task automatic test_width1;
      logic a, b, c, ed, eb;
      for (int v = 0; v < 8; v++) begin
         a = v[2]; b = v[1]; c = v[0];
         ed = a ^ b ^ c;
         eb = (int'(a) < int'(b) + int'(c));
         @(negedge clock);
         s1_start = 1'b1; s1_a = a; s1_b = b; s1_bin = c;
         @(posedge clock);
         #1 s1_start = 1'b0;
         @(negedge clock);
         total++; if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin bad++; $display("FAIL w1_run%0d busy=%b done=%b want 1 0", v, s1_busy, s1_done); end
         @(negedge clock);
         total++; if (s1_done !== 1'b1) begin bad++; $display("FAIL w1_done%0d got=%b want=1", v, s1_done); end
         total++; if (s1_diff !== ed || s1_borrow !== eb) begin bad++; $display("FAIL w1_res%0d diff=%b borrow=%b want %b %b", v, s1_diff, s1_borrow, ed, eb); end
         $display("w1 op %b-%b-%b diff=%b borrow=%b", a, b, c, s1_diff, s1_borrow);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_borrow;
      test_back_to_back;
      test_ignore_start;
      test_reset_mid_run;
      test_random;
`ifdef SERSUB_OVERFLOW_EN
      test_overflow;
`endif
      test_width1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
